dmem_mmio: RTL and testbench

//  Data-side memory for the single-cycle core: consumes its address (aluresult), writedata and
//  4-bit byte-lane write enables, and returns readdata in the same cycle. Decodes a RAM region
//  and an MMIO region. The MMIO region holds a TX FIFO feeding a UART transmitter (8N1).

---
 rtl/dmem_mmio_pkg.sv | 23 ++
 rtl/mmio_fifo.sv | 50 +++++
 rtl/dmem_mmio.sv | 179 +++++++++++++++++
 tb/tb_dmem_mmio.sv | 133 +++++++++++++
 4 files changed

// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data memory / MMIO block: region base, register offsets,
// TX state encodings and STATUS bit positions.
package dmem_mmio_pkg;

  localparam logic [31:0] MMIO_BASE   = 32'hFFFF_0000;

  localparam logic [1:0]  MMIO_TXDATA = 2'd0;
  localparam logic [1:0]  MMIO_STATUS = 2'd1;
  localparam logic [1:0]  MMIO_CYCLES = 2'd2;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/mmio_fifo.sv
// Synchronous byte FIFO for the UART TX path. A push while full is accepted only
// when a pop happens in the same cycle.
module mmio_fifo #(
  parameter int FIFO_AW = 3,
  parameter int W       = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW+1)'(1 << FIFO_AW);

  logic [W-1:0]       mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0]   count;
  logic               do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data memory with an MMIO window holding a TX FIFO and 8N1 UART transmitter.
// Define DMEM_MMIO_CYCLE_CNT_EN to add a 32-bit cycle counter at MMIO offset 2.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int DMEM_AW      = 10,
  parameter int FIFO_AW      = 3,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [31:0]        mem [2**DMEM_AW];
  logic [DMEM_AW-1:0] widx;
  logic               is_ram, is_mmio, wr;
  logic [1:0]         off;
  logic [7:0]         tx_byte, fifo_dout;
  logic               push, pop, status_wr, fifo_full, fifo_empty;
  logic               overflow;
  logic [31:0]        status;
  logic               unused_addr_lsb;

  tx_state_e          state;
  logic [CW-1:0]      baud;
  logic [2:0]         bit_idx;
  logic [7:0]         shreg;
  logic               baud_end;

  assign is_ram    = (addr[31:DMEM_AW+2] == '0);
  assign is_mmio   = (addr[31:4] == MMIO_BASE[31:4]);
  assign widx      = addr[DMEM_AW+1:2];
  assign off       = addr[3:2];
  assign wr        = |be;
  assign push      = is_mmio && (off == MMIO_TXDATA) && wr;
  assign status_wr = is_mmio && (off == MMIO_STATUS) && wr;
  assign unused_addr_lsb = ^addr[1:0];

  // A one-hot enable picks its lane; anything else takes the low byte.
  always_comb begin
    tx_byte = wdata[7:0];
    case (be)
      4'b0010: tx_byte = wdata[15:8];
      4'b0100: tx_byte = wdata[23:16];
      4'b1000: tx_byte = wdata[31:24];
      default: tx_byte = wdata[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (is_ram) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  mmio_fifo #(.FIFO_AW(FIFO_AW), .W(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (tx_byte),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst)                                 overflow <= 1'b0;
    else if (status_wr)                      overflow <= 1'b0;
    else if (push && fifo_full && !pop)      overflow <= 1'b1;
  end

  assign baud_end = (baud == CW'(CLKS_PER_BIT - 1));
  assign pop = !fifo_empty && ((state == TX_IDLE) || (state == TX_STOP && baud_end));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= TX_IDLE;
      uart_tx <= 1'b1;
      tx_busy <= 1'b0;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        TX_IDLE: begin
          baud <= '0;
          if (!fifo_empty) begin
            shreg   <= fifo_dout;
            state   <= TX_START;
            uart_tx <= 1'b0;
            tx_busy <= 1'b1;
          end
        end
        TX_START: begin
          if (baud_end) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= TX_DATA;
            uart_tx <= shreg[0];
          end else baud <= baud + 1'b1;
        end
        TX_DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              state   <= TX_STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg >> 1;
              uart_tx <= shreg[1];
            end
          end else baud <= baud + 1'b1;
        end
        TX_STOP: begin
          if (baud_end) begin
            baud <= '0;
            // Chain straight into the next frame so there is no idle gap.
            if (!fifo_empty) begin
              shreg   <= fifo_dout;
              state   <= TX_START;
              uart_tx <= 1'b0;
            end else begin
              state   <= TX_IDLE;
              tx_busy <= 1'b0;
            end
          end else baud <= baud + 1'b1;
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  always_comb begin
    status           = '0;
    status[ST_EMPTY] = fifo_empty;
    status[ST_FULL]  = fifo_full;
    status[ST_BUSY]  = tx_busy;
    status[ST_OVF]   = overflow;
  end

`ifdef DMEM_MMIO_CYCLE_CNT_EN
  logic [31:0] cycles;
  logic        cyc_wr;

  assign cyc_wr = is_mmio && (off == MMIO_CYCLES) && wr;

  always_ff @(posedge clk) begin
    if (rst || cyc_wr) cycles <= '0;
    else               cycles <= cycles + 32'd1;
  end
`else
  logic [31:0] cycles;
  assign cycles = '0;
`endif

  always_comb begin
    rdata = '0;
    if (is_ram) rdata = mem[widx];
    else if (is_mmio) begin
      case (off)
        MMIO_STATUS: rdata = status;
        MMIO_CYCLES: rdata = cycles;
        default:     rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM byte lanes, decode, UART framing, FIFO overflow,
// reset abort and (with DMEM_MMIO_CYCLE_CNT_EN) the cycle counter.
module tb_dmem_mmio;

  localparam int CPB = 4;
  localparam logic [31:0] TXD = 32'hFFFF_0000;
  localparam logic [31:0] STA = 32'hFFFF_0004;
  localparam logic [31:0] CYC = 32'hFFFF_0008;
  localparam logic [31:0] RSV = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic        uart_tx, tx_busy;
  int          checks = 0;
  int          failures = 0;

  dmem_mmio #(.DMEM_AW(10), .FIFO_AW(3), .CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .wdata   (wdata),
    .be      (be),
    .rdata   (rdata),
    .uart_tx (uart_tx),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a; wdata = d; be = b;
    tick();
    be = 4'b0000;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a; be = 4'b0000;
    #1;
    check(tag, rdata, exp);
  endtask

  // Starts on the first cycle of the START bit; walks the 10 bit windows.
  task automatic check_frame(input string tag, input logic [7:0] b);
    logic e;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < CPB; c++) begin
        e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
        check(tag, {31'b0, uart_tx}, {31'b0, e});
        if (c == 0) check({tag, "_busy"}, {31'b0, tx_busy}, 32'd1);
        tick();
      end
    end
  endtask

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; be = 4'b0000;
    tick(); tick();
    rst = 1'b0;
    check("rst_tx", {31'b0, uart_tx}, 32'd1);
    check("rst_busy", {31'b0, tx_busy}, 32'd0);
    rd("rst_status", STA, 32'h1);

    wr(32'h40, 32'h1122_3344, 4'b1111);
    wr(32'h42, 32'h0000_AA00, 4'b0010);
    rd("ram_sb", 32'h40, 32'h1122_AA44);
    wr(32'h1000_0040, 32'hDEAD_BEEF, 4'b1111);
    rd("ram_unmapped_wr", 32'h40, 32'h1122_AA44);
    rd("unmapped_rd", 32'h1000_0000, 32'h0);
    tick();
    rd("txdata_rd", TXD, 32'h0);
    rd("reserved_rd", RSV, 32'h0);

    wr(TXD, 32'h5500_0000, 4'b1000);
    check("push_tx_high", {31'b0, uart_tx}, 32'd1);
    rd("push_status", STA, 32'h0);
    tick();
    check_frame("frame55", 8'h55);
    check("frame55_idle_busy", {31'b0, tx_busy}, 32'd0);
    check("frame55_idle_tx", {31'b0, uart_tx}, 32'd1);
    rd("frame55_status", STA, 32'h1);

    for (int i = 1; i <= 9; i++) wr(TXD, i, 4'b1111);
    rd("fill_status", STA, 32'h6);
    wr(TXD, 32'h0A, 4'b1111);
    rd("ovf_status", STA, 32'hE);
    wr(STA, 32'h0, 4'b0001);
    rd("ovf_clear", STA, 32'h6);

    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_tx", {31'b0, uart_tx}, 32'd1);
    check("abort_busy", {31'b0, tx_busy}, 32'd0);
    rd("abort_status", STA, 32'h1);

    wr(TXD, 32'h00A5_0000, 4'b0100);
    wr(TXD, 32'hFFFF_FF3C, 4'b1111);
    check_frame("frameA5", 8'hA5);
    check_frame("frame3C", 8'h3C);
    check("b2b_idle_busy", {31'b0, tx_busy}, 32'd0);
    rd("b2b_status", STA, 32'h1);

`ifdef DMEM_MMIO_CYCLE_CNT_EN
    wr(CYC, 32'h0, 4'b1111);
    rd("cyc_clear", CYC, 32'd0);
    repeat (10) tick();
    rd("cyc_10", CYC, 32'd10);
`else
    wr(CYC, 32'h1234, 4'b1111);
    rd("cyc_disabled", CYC, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
